// File: rtl/matmul_sequencer.sv
// Sequencing controller for an NxN matrix multiply: walks (i,j,k), drives operand
// read addresses, accumulates products and writes each C element once, row-major.
module matmul_sequencer #(
  parameter int N  = 2,
  parameter int DW = 8,
  parameter int AW = ($clog2(N*N) > 0) ? $clog2(N*N) : 1,
  parameter int CW = 2*DW + $clog2(N)
) (
  input  logic          hz100,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          ready,
  output logic          done,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  input  logic [DW-1:0] a_data,
  input  logic [DW-1:0] b_data,
  output logic          c_we,
  output logic [AW-1:0] c_addr,
  output logic [CW-1:0] c_data
);

  localparam int IW = ($clog2(N) > 0) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N-1);

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [CW-1:0] product;

  assign product = CW'(a_data) * CW'(b_data);

  always_ff @(posedge hz100) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = MAC;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      MAC: begin
        // k==0 starts a fresh dot product, so no separate clear cycle is needed
        acc_d = ((k_q == '0) ? '0 : acc_q) + product;
        if (k_q == LAST) begin
          k_d     = '0;
          state_d = WRITE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      WRITE: begin
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d     = '0;
            state_d = DONE;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = MAC;
          end
        end else begin
          j_d     = j_q + 1'b1;
          state_d = MAC;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      i_d     = '0;
      j_d     = '0;
      k_d     = '0;
      acc_d   = '0;
    end
  end

  assign busy   = (state_q != IDLE);
  assign ready  = (state_q == IDLE);
  assign done   = (state_q == DONE);
  assign c_we   = (state_q == WRITE);
  assign a_addr = AW'(i_q) * AW'(N) + AW'(k_q);
  assign b_addr = AW'(k_q) * AW'(N) + AW'(j_q);
  assign c_addr = AW'(i_q) * AW'(N) + AW'(j_q);
  assign c_data = acc_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: random and directed matrices compared
// against a plain triple-loop matrix product, plus start/abort/reset scenarios.
module tb_matmul_sequencer;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int CW = 17;
  localparam int DONE_CYCLE = N*N*(N+1) + 1;

  logic          hz100 = 1'b0;
  logic          reset, start, abort;
  logic          busy, ready, done, c_we;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic [DW-1:0] a_data, b_data;
  logic [CW-1:0] c_data;

  logic [DW-1:0] memA [N*N];
  logic [DW-1:0] memB [N*N];
  int unsigned   refC [N*N];

  int          testsRun = 0;
  int          testsFailed = 0;
  int          wAddr [$];
  int unsigned wData [$];
  int          doneAt, doneCount, busyCount, endCycle;
  bit          timedOut;
  int          aSeq [4];
  int          bSeq [4];

  matmul_sequencer #(.N(N), .DW(DW)) dut (
    .hz100(hz100), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .ready(ready), .done(done),
    .a_addr(a_addr), .b_addr(b_addr), .a_data(a_data), .b_data(b_data),
    .c_we(c_we), .c_addr(c_addr), .c_data(c_data)
  );

  always #5 hz100 = ~hz100;

  assign a_data = memA[a_addr];
  assign b_data = memB[b_addr];

  // Reference product straight from the definition C[r][c] = sum_k A[r][k]*B[k][c]
  function automatic void computeRef();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        int unsigned s = 0;
        for (int k = 0; k < N; k++) s += 32'(memA[r*N+k]) * 32'(memB[k*N+c]);
        refC[r*N+c] = s;
      end
    end
  endfunction

  function automatic void randomMatrices();
    for (int e = 0; e < N*N; e++) begin
      memA[e] = 8'($urandom_range(0, 255));
      memB[e] = 8'($urandom_range(0, 255));
    end
    computeRef();
  endfunction

  // Pulses start and records writes, done and busy until the block is back in IDLE
  task automatic applyStimulus(input bit heldMode);
    wAddr.delete();
    wData.delete();
    doneAt = -1; doneCount = 0; busyCount = 0; endCycle = 0; timedOut = 1'b1;
    @(negedge hz100); start = 1'b1;
    @(negedge hz100); start = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc <= 4) begin aSeq[cyc-1] = int'(a_addr); bSeq[cyc-1] = int'(b_addr); end
      if (ready) begin timedOut = 1'b0; endCycle = cyc; start = 1'b0; break; end
      if (busy) busyCount++;
      if (c_we) begin wAddr.push_back(int'(c_addr)); wData.push_back(32'(c_data)); end
      if (done) begin doneCount++; doneAt = cyc; end
      if (heldMode) start = ((cyc >= 2 && cyc <= 6) || done);
      @(negedge hz100);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge hz100);
    testsRun++;
    if ({busy, ready, done, c_we} !== 4'b0100) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got busy/ready/done/c_we=%b expected 0100", {busy, ready, done, c_we});
    end
    testsRun++;
    if ({a_addr, b_addr, c_addr, c_data} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_buses: got a=%0d b=%0d c=%0d data=%0d expected all 0", a_addr, b_addr, c_addr, c_data);
    end
    reset = 1'b0;
    @(negedge hz100);
    testsRun++;
    if (ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", ready);
    end
  endtask

  task automatic test_basic();
    memA = '{8'd1, 8'd2, 8'd3, 8'd4};
    memB = '{8'd5, 8'd6, 8'd7, 8'd8};
    computeRef();
    applyStimulus(1'b0);
    testsRun++;
    if (timedOut || wAddr.size() != N*N) begin
      testsFailed++;
      $display("[TB] FAIL basic_writes: got %0d writes (timeout=%0d) expected %0d", wAddr.size(), timedOut, N*N);
    end
    for (int e = 0; e < wAddr.size() && e < N*N; e++) begin
      testsRun++;
      if (wAddr[e] != e || wData[e] != refC[e]) begin
        testsFailed++;
        $display("[TB] FAIL basic_c%0d: got addr=%0d data=%0d expected addr=%0d data=%0d", e, wAddr[e], wData[e], e, refC[e]);
      end
    end
    testsRun++;
    if (doneAt != DONE_CYCLE || doneCount != 1) begin
      testsFailed++;
      $display("[TB] FAIL basic_done: got cycle=%0d count=%0d expected cycle=%0d count=1", doneAt, doneCount, DONE_CYCLE);
    end
    testsRun++;
    if (busyCount != DONE_CYCLE || endCycle != DONE_CYCLE + 1) begin
      testsFailed++;
      $display("[TB] FAIL basic_busy: got busy=%0d idleAt=%0d expected busy=%0d idleAt=%0d", busyCount, endCycle, DONE_CYCLE, DONE_CYCLE + 1);
    end
  endtask

  task automatic test_max();
    for (int e = 0; e < N*N; e++) begin memA[e] = 8'hFF; memB[e] = 8'hFF; end
    computeRef();
    applyStimulus(1'b0);
    testsRun++;
    if (timedOut || wAddr.size() != N*N) begin
      testsFailed++;
      $display("[TB] FAIL max_writes: got %0d writes expected %0d", wAddr.size(), N*N);
    end
    for (int e = 0; e < wAddr.size() && e < N*N; e++) begin
      testsRun++;
      if (wAddr[e] != e || wData[e] != refC[e]) begin
        testsFailed++;
        $display("[TB] FAIL max_c%0d: got addr=%0d data=%0d expected addr=%0d data=%0d", e, wAddr[e], wData[e], e, refC[e]);
      end
    end
  endtask

  task automatic test_identity();
    memA = '{8'd1, 8'd0, 8'd0, 8'd1};
    memB = '{8'd9, 8'd8, 8'd7, 8'd6};
    computeRef();
    applyStimulus(1'b0);
    testsRun++;
    if (aSeq[0] != 0 || bSeq[0] != 0 || aSeq[1] != 1 || bSeq[1] != 2) begin
      testsFailed++;
      $display("[TB] FAIL identity_addr: got (%0d,%0d),(%0d,%0d) expected (0,0),(1,2)", aSeq[0], bSeq[0], aSeq[1], bSeq[1]);
    end
    testsRun++;
    if (wData.size() != N*N || wData[0] != 9 || wData[1] != 8 || wData[2] != 7 || wData[3] != 6) begin
      testsFailed++;
      $display("[TB] FAIL identity_c: got %0d writes expected C equal to B (9,8,7,6)", wData.size());
    end
  endtask

  task automatic test_random();
    for (int run = 0; run < 4; run++) begin
      randomMatrices();
      applyStimulus(1'b0);
      testsRun++;
      if (timedOut || wAddr.size() != N*N || doneCount != 1) begin
        testsFailed++;
        $display("[TB] FAIL random%0d_shape: got %0d writes %0d done expected %0d writes 1 done", run, wAddr.size(), doneCount, N*N);
      end
      for (int e = 0; e < wAddr.size() && e < N*N; e++) begin
        testsRun++;
        if (wAddr[e] != e || wData[e] != refC[e]) begin
          testsFailed++;
          $display("[TB] FAIL random%0d_c%0d: got addr=%0d data=%0d expected addr=%0d data=%0d", run, e, wAddr[e], wData[e], e, refC[e]);
        end
      end
    end
  endtask

  task automatic test_start_held();
    randomMatrices();
    applyStimulus(1'b1);
    testsRun++;
    if (timedOut || wAddr.size() != N*N || doneCount != 1) begin
      testsFailed++;
      $display("[TB] FAIL held_single_run: got %0d writes %0d done expected %0d writes 1 done", wAddr.size(), doneCount, N*N);
    end
    @(negedge hz100);
    testsRun++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL held_no_restart: got ready=%b busy=%b expected ready=1 busy=0", ready, busy);
    end
    randomMatrices();
    applyStimulus(1'b0);
    testsRun++;
    if (wData.size() != N*N || wData[N*N-1] != refC[N*N-1] || wData[0] != refC[0]) begin
      testsFailed++;
      $display("[TB] FAIL held_second_run: got %0d writes expected %0d correct writes", wData.size(), N*N);
    end
  endtask

  task automatic test_abort();
    int sawDone = 0;
    randomMatrices();
    wAddr.delete();
    wData.delete();
    @(negedge hz100); start = 1'b1;
    @(negedge hz100); start = 1'b0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      if (c_we) begin wAddr.push_back(int'(c_addr)); wData.push_back(32'(c_data)); end
      if (done) sawDone++;
      if (cyc == 5) abort = 1'b1;
      @(negedge hz100);
    end
    abort = 1'b0;
    testsRun++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL abort_idle: got ready=%b busy=%b expected ready=1 busy=0", ready, busy);
    end
    repeat (6) begin
      if (c_we) begin wAddr.push_back(int'(c_addr)); wData.push_back(32'(c_data)); end
      if (done) sawDone++;
      @(negedge hz100);
    end
    testsRun++;
    if (wAddr.size() != 1 || sawDone != 0) begin
      testsFailed++;
      $display("[TB] FAIL abort_writes: got %0d writes %0d done expected 1 write 0 done", wAddr.size(), sawDone);
    end else begin
      testsRun++;
      if (wAddr[0] != 0 || wData[0] != refC[0]) begin
        testsFailed++;
        $display("[TB] FAIL abort_c0: got addr=%0d data=%0d expected addr=0 data=%0d", wAddr[0], wData[0], refC[0]);
      end
    end
    randomMatrices();
    applyStimulus(1'b0);
    for (int e = 0; e < N*N; e++) begin
      testsRun++;
      if (e >= wAddr.size() || wAddr[e] != e || wData[e] != refC[e]) begin
        testsFailed++;
        $display("[TB] FAIL abort_rerun_c%0d: got %0d writes expected data=%0d at addr %0d", e, wAddr.size(), refC[e], e);
      end
    end
  endtask

  task automatic test_reset_midrun();
    randomMatrices();
    @(negedge hz100); start = 1'b1;
    @(negedge hz100); start = 1'b0;
    repeat (3) @(negedge hz100);
    reset = 1'b1; start = 1'b1;
    @(negedge hz100);
    testsRun++;
    if ({busy, ready, done, c_we, a_addr, b_addr, c_addr, c_data} !== {4'b0100, {(3*AW+CW){1'b0}}}) begin
      testsFailed++;
      $display("[TB] FAIL midrun_reset: got busy=%b ready=%b done=%b we=%b a=%0d b=%0d c=%0d data=%0d expected reset values",
               busy, ready, done, c_we, a_addr, b_addr, c_addr, c_data);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge hz100);
    applyStimulus(1'b0);
    for (int e = 0; e < N*N; e++) begin
      testsRun++;
      if (e >= wAddr.size() || wAddr[e] != e || wData[e] != refC[e]) begin
        testsFailed++;
        $display("[TB] FAIL reset_rerun_c%0d: got %0d writes expected data=%0d at addr %0d", e, wAddr.size(), refC[e], e);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    for (int e = 0; e < N*N; e++) begin memA[e] = '0; memB[e] = '0; end
    test_reset();
    test_basic();
    test_max();
    test_identity();
    test_random();
    test_start_held();
    test_abort();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Sequencing controller for the matrix-multiply datapath behind the SPI front end.
- Once the SPI loader has filled operand register files A and B, the block walks every (i,j,k) index and drives the operand read addresses.
- It owns the multiply-accumulate and writes each C element to the result file.
- It reports busy/done so the SPI side can gate host access and drive the external ready pin.

Parameters:
- N, 2, matrix dimension (square NxN); legal 2..4.
- DW, 8, operand width, unsigned.
- AW, $clog2(N*N) (min 1), element address width; row-major index = row*N+col.
- CW, 2*DW+$clog2(N), result/accumulator width; never overflows.

Ports:
- hz100  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a multiply; sampled only in IDLE
- abort  input  1  synchronous cancel; returns to IDLE next edge
- busy  output  1  high in MAC/WRITE/DONE; SPI loader must not write A/B/C while high
- ready  output  1  high only in IDLE (drives external ready pin)
- done  output  1  one-cycle pulse on completion
- a_addr  output  AW  A read address
- b_addr  output  AW  B read address
- a_data  input  DW  A read data, asynchronous (same-cycle) read
- b_data  input  DW  B read data, asynchronous read
- c_we  output  1  C write strobe
- c_addr  output  AW  C write address
- c_data  output  CW  C write data

Behaviour:
Reset and outputs:
- reset has priority over everything; takes effect at the next hz100 edge.
- Reset values: state=IDLE, i=j=k=0, acc=0, busy=0, ready=1, done=0, c_we=0, a_addr=b_addr=c_addr=0, c_data=0.

States: IDLE, MAC, WRITE, DONE.
- IDLE: ready=1. start=1 -> MAC with i=j=k=0. start ignored in every other state (no queuing).
- MAC: a_addr=i*N+k, b_addr=k*N+j (combinational from counters).
  - Each cycle: acc <= (k==0 ? 0 : acc) + a_data*b_data, unsigned, zero-extended to CW.
  - k<N-1: k++, stay in MAC. k==N-1: k<=0, go to WRITE.
- WRITE: one cycle. c_we=1, c_addr=i*N+j, c_data=acc (registered acc, so the last product is included).
  - Then advance j; on j wrap to 0, advance i.
  - If i==N-1 and j==N-1: go to DONE. Else go to MAC.
- DONE: done=1 for exactly one cycle, busy still 1, c_we=0. Next state is IDLE.

Timing:
- Total from start-sampling edge to done high = N*N*(N+1) cycles, then one DONE cycle. N=2: 12 MAC/WRITE cycles, done high in cycle 13.
- start asserted during the DONE cycle is ignored. The earliest restart is the first IDLE cycle after DONE.
- c_we is high only in WRITE and only for one cycle per element. Each C address is written exactly once per run, in row-major order.

Abort and reset:
- abort in MAC/WRITE/DONE: next state IDLE, counters and acc cleared, no further C writes, done not pulsed.
- C elements already written keep their values.
- abort in IDLE has no effect. If abort and start are both high in IDLE, abort wins and the block stays IDLE.
- reset mid-operation behaves as abort, and also clears c_data.

Arithmetic:
- All arithmetic unsigned.
- The max element N*(2^DW-1)^2 fits in CW bits; no saturation logic.

Test Plan:
- Basic multiply, N=2, DW=8: A=[[1,2],[3,4]], B=[[5,6],[7,8]], start pulse -> C writes at addr 0,1,2,3 = 19,22,43,50. done pulses in cycle 13 after start; busy high for 13 cycles; ready low throughout.
- Max values: all A,B=255 -> every C=130050 (17'h1FC02). No overflow; exactly 4 c_we pulses.
- Identity: A=I, B=[[9,8],[7,6]] -> C=B. a_addr/b_addr sequence in the first MAC pair = (0,0),(1,2).
- start held high for 5 cycles mid-run and during DONE -> only one run executes. The second run begins only on the first start sampled in IDLE.
- abort asserted on the 6th cycle after start (during the 2nd element's MAC) -> returns to IDLE. Only addr 0 written; no done pulse; ready=1 next cycle. A new start then gives a full correct result.
- reset asserted mid-run together with start -> all outputs at reset values next edge, no c_we. A subsequent start gives correct C.
